// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch controller states (BOOT, RUN, HALT)
//   FAULT_*       : encodings reported on Fault_Code
//   DEFAULT_NOP   : default bubble instruction (addi x0, x0, 0)
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register between fetch and decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_i          : capture pc_i / pc_plus4_i / instr_i as a valid entry
//   bubble_i        : insert a NOP bubble (valid cleared, instr = NOP_INSTR)
//   kill_i          : clear valid only, all data fields hold
//   pc_i, pc_plus4_i, instr_i : fetch-side data
//   pc_o, pc_plus4_o, instr_o, valid_o : registered outputs to decode
// Priority: load > bubble > kill > hold.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        kill_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (load_i) begin
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      instr_d    = instr_i;
      valid_d    = 1'b1;
    end else if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (kill_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule : if_id_register

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT controller, fetch
// counter, and the IF/ID register feeding decode.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   Instr_Data       : instruction word for Instr_Address (combinational memory)
//   Stall            : decode back-pressure, holds PC and IF/ID
//   Redirect, Redirect_Target : taken branch/jump and its byte address
//   Instr_Address    : current PC
//   IFID_PC, IFID_PC_Plus4, IFID_Instr, IFID_Valid : IF/ID register to decode
//   Halted, Fault_Code : fetch stopped, and why (01 misaligned, 10 out of range)
//   Fetch_Count      : saturating count of valid IF/ID latches
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr_Data,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] Instr_Address,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC_Plus4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [1:0]  Fault_Code,
  output logic [31:0] Fetch_Count
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [31:0] LAST_ADDR  = IMEM_LIMIT - 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   fault_q, fault_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         ifid_kill;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_kill   = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        pc_d    = RESET_PC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (Redirect) begin
          // Redirect wins over Stall; a bad target stops fetch at the current PC.
          if (Redirect_Target[1:0] != 2'b00) begin
            state_d   = ST_HALT;
            fault_d   = FAULT_MISALIGN;
            ifid_kill = 1'b1;
          end else if (Redirect_Target >= IMEM_LIMIT) begin
            state_d   = ST_HALT;
            fault_d   = FAULT_RANGE;
            ifid_kill = 1'b1;
          end else begin
            pc_d        = Redirect_Target;
            ifid_bubble = 1'b1;
          end
        end else if (!Stall) begin
          ifid_load = 1'b1;
          if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
          end
          // The last word is still delivered; the PC never steps past it,
          // so the PC+4 wrap can never reach the memory address.
          if (pc_q >= LAST_ADDR) begin
            state_d = ST_HALT;
            fault_d = FAULT_RANGE;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        // Clears the final instruction latched on the way into HALT after
        // decode has had it for one cycle.
        ifid_kill = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= FAULT_NONE;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .kill_i     (ifid_kill),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (Instr_Data),
    .pc_o       (IFID_PC),
    .pc_plus4_o (IFID_PC_Plus4),
    .instr_o    (IFID_Instr),
    .valid_o    (IFID_Valid)
  );

  assign Instr_Address = pc_q;
  assign Halted        = (state_q == ST_HALT);
  assign Fault_Code    = fault_q;
  assign Fetch_Count   = count_q;

endmodule : fetch_stage
